// File: rtl/move_avg_ctrl.sv
// Sequencer between a codec sample stream and an external moving-average filter.
// Handles filter warm-up, enable/disable flushing, write timeout and overrun flags.
module move_avg_ctrl #(
    parameter int WARMUP      = 8,
    parameter int TIMEOUT     = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] in_sample,
    input  logic        in_strobe,
    input  logic        fx_req,
    input  logic        clr_err,
    output logic [23:0] flt_data,
    output logic        flt_wren,
    output logic        flt_on,
    output logic        flt_reset,
    input  logic [23:0] flt_out,
    input  logic        flt_valid,
    output logic [23:0] out_sample,
    output logic        out_strobe,
    output logic        fx_active,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);

    localparam int WW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [WW-1:0] WARM_MAX = WW'(WARMUP);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    logic [1:0]             state;
    logic [1:0]             state_nx;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   fx_sync;
    logic [23:0]            byp;
    logic [WW-1:0]          warm_cnt;
    logic [TW-1:0]          timer;
    logic                   wait_hit;
    logic                   wait_tmo;
    logic                   go_flush;
    logic                   go_off;
    logic                   warm_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= fx_req;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign fx_sync = sync_q[SYNC_STAGES-1];

    // timer holds the number of WAIT cycles already spent
    always_comb begin
        wait_hit  = (state == WAIT) && flt_valid;
        wait_tmo  = (state == WAIT) && !flt_valid && (timer == TMO_LAST);
        go_flush  = (state == IDLE) && !in_strobe && fx_sync && !fx_active;
        go_off    = (state == IDLE) && !in_strobe && !fx_sync && fx_active;
        warm_done = (warm_cnt == WARM_MAX);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_strobe) begin
                    state_nx = ISSUE;
                end else if (go_flush) begin
                    state_nx = FLUSH;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (wait_hit || wait_tmo) begin
                    state_nx = IDLE;
                end
            end
            FLUSH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            flt_data   <= '0;
            byp        <= '0;
            out_sample <= '0;
            flt_wren   <= 1'b0;
            flt_reset  <= 1'b0;
            out_strobe <= 1'b0;
            fx_active  <= 1'b0;
            warm_cnt   <= '0;
            timer      <= '0;
        end else begin
            state      <= state_nx;
            flt_wren   <= (state_nx == ISSUE);
            flt_reset  <= (state_nx == FLUSH);
            out_strobe <= wait_hit || wait_tmo;

            if ((state == IDLE) && in_strobe) begin
                flt_data <= in_sample;
                byp      <= in_sample;
            end

            if (state == ISSUE) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + 1'b1;
            end

            if (wait_hit) begin
                out_sample <= (fx_active && warm_done) ? flt_out : byp;
                if (!warm_done) begin
                    warm_cnt <= warm_cnt + 1'b1;
                end
            end

            if (wait_tmo) begin
                out_sample <= byp;
            end

            if (state == FLUSH) begin
                warm_cnt  <= '0;
                fx_active <= 1'b1;
            end

            if (go_off) begin
                warm_cnt  <= '0;
                fx_active <= 1'b0;
            end
        end
    end

    // a new error event in the same cycle beats clr_err
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (in_strobe && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end

            if (wait_tmo) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

    assign busy   = (state != IDLE);
    assign flt_on = fx_active;

endmodule

// File: tb/tb_move_avg_ctrl.sv
// Directed bench for move_avg_ctrl with a one-cycle filter model whose
// result is the bitwise inverse of its input, so filtered and bypass differ.
module tb_move_avg_ctrl;

    localparam int WARMUP      = 8;
    localparam int TIMEOUT     = 15;
    localparam int SYNC_STAGES = 2;
    localparam logic [23:0] BAD = 24'hBADBAD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] in_sample = '0;
    logic        in_strobe = 1'b0;
    logic        fx_req = 1'b0;
    logic        clr_err = 1'b0;
    logic [23:0] flt_data;
    logic        flt_wren;
    logic        flt_on;
    logic        flt_reset;
    logic [23:0] flt_out = '0;
    logic        flt_valid = 1'b0;
    logic [23:0] out_sample;
    logic        out_strobe;
    logic        fx_active;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    logic mute = 1'b0;

    int checks = 0;
    int errors = 0;

    int   n_wren = 0;
    int   n_frst = 0;
    int   n_ostb = 0;
    int   n_dbl  = 0;
    logic p_wren = 1'b0;
    logic p_frst = 1'b0;
    logic p_ostb = 1'b0;
    logic bad_seen = 1'b0;

    typedef struct {
        logic        fx;
        logic [23:0] smp;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl [15];

    always #5 clk = ~clk;

    move_avg_ctrl #(
        .WARMUP(WARMUP),
        .TIMEOUT(TIMEOUT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_sample(in_sample),
        .in_strobe(in_strobe),
        .fx_req(fx_req),
        .clr_err(clr_err),
        .flt_data(flt_data),
        .flt_wren(flt_wren),
        .flt_on(flt_on),
        .flt_reset(flt_reset),
        .flt_out(flt_out),
        .flt_valid(flt_valid),
        .out_sample(out_sample),
        .out_strobe(out_strobe),
        .fx_active(fx_active),
        .busy(busy),
        .overrun(overrun),
        .timeout_err(timeout_err)
    );

    always @(posedge clk) begin
        if (reset) begin
            flt_valid <= 1'b0;
        end else begin
            flt_valid <= flt_wren && !mute;
            flt_out   <= ~flt_data;
        end
    end

    always @(negedge clk) begin
        if (flt_wren)   n_wren <= n_wren + 1;
        if (flt_reset)  n_frst <= n_frst + 1;
        if (out_strobe) n_ostb <= n_ostb + 1;
        if ((flt_wren && p_wren) || (flt_reset && p_frst) || (out_strobe && p_ostb))
            n_dbl <= n_dbl + 1;
        if (flt_data == BAD) bad_seen <= 1'b1;
        p_wren <= flt_wren;
        p_frst <= flt_reset;
        p_ostb <= out_strobe;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // lat counts cycles from the in_strobe cycle (as 1) to the out_strobe cycle
    task automatic xfer(input logic [23:0] s, output logic [23:0] got, output int lat);
        in_sample = s;
        in_strobe = 1'b1;
        lat = 1;
        @(negedge clk);
        in_strobe = 1'b0;
        lat = 2;
        while (!out_strobe && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        got = out_sample;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] got;
        int lat;
        int snap_o;
        int snap_w;
        int snap_r;

        tbl[0] = '{1'b0, 24'h000100, 24'h000100};
        tbl[1] = '{1'b0, 24'h800000, 24'h800000};
        tbl[2] = '{1'b0, 24'h7FFFFF, 24'h7FFFFF};
        tbl[3] = '{1'b0, 24'hFFFFFF, 24'hFFFFFF};
        tbl[4] = '{1'b0, 24'h000000, 24'h000000};
        for (int i = 5; i < 13; i++) tbl[i] = '{1'b1, 24'h7FFFFF, 24'h7FFFFF};
        tbl[13] = '{1'b1, 24'h7FFFFF, 24'h800000};
        tbl[14] = '{1'b1, 24'h7FFFFF, 24'h800000};

        repeat (3) @(negedge clk);
        check("rst_flt_data", 32'(flt_data), 32'h0);
        check("rst_out_sample", 32'(out_sample), 32'h0);
        check("rst_flags", 32'({flt_wren, flt_reset, out_strobe, fx_active,
                                flt_on, busy, overrun, timeout_err}), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            if (fx_req != tbl[i].fx) begin
                fx_req = tbl[i].fx;
                repeat (6) @(negedge clk);
            end
            xfer(tbl[i].smp, got, lat);
            check($sformatf("vec%0d_data", i), 32'(got), 32'(tbl[i].exp));
            check($sformatf("vec%0d_lat", i), lat, 4);
            check($sformatf("vec%0d_fx", i), 32'(fx_active), 32'(tbl[i].fx));
            @(negedge clk);
        end
        check("flush_pulses", n_frst, 1);
        check("wren_pulses", n_wren, 15);
        check("flt_on_eq", 32'(flt_on), 32'h1);

        mute = 1'b1;
        xfer(24'h123456, got, lat);
        check("tmo_data", 32'(got), 32'h123456);
        check("tmo_lat", lat, 3 + TIMEOUT);
        check("tmo_err", 32'(timeout_err), 32'h1);
        repeat (3) @(negedge clk);
        check("tmo_sticky", 32'(timeout_err), 32'h1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("tmo_clr", 32'(timeout_err), 32'h0);
        mute = 1'b0;
        xfer(24'h000001, got, lat);
        check("post_tmo_data", 32'(got), 32'hFFFFFE);
        check("post_tmo_lat", lat, 4);
        @(negedge clk);

        snap_o = n_ostb;
        in_sample = 24'h00AAAA;
        in_strobe = 1'b1;
        @(negedge clk);
        in_strobe = 1'b0;
        @(negedge clk);
        in_sample = BAD;
        in_strobe = 1'b1;
        clr_err = 1'b1;
        @(negedge clk);
        in_strobe = 1'b0;
        clr_err = 1'b0;
        repeat (6) @(negedge clk);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_one_out", n_ostb - snap_o, 1);
        check("ovr_data", 32'(out_sample), 32'hFF5555);
        check("ovr_no_bad", 32'(bad_seen), 32'h0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("ovr_clr", 32'(overrun), 32'h0);

        snap_r = n_frst;
        fx_req = 1'b0;
        repeat (6) @(negedge clk);
        check("off_fx", 32'(fx_active), 32'h0);
        check("off_no_flush", n_frst - snap_r, 0);

        fx_req = 1'b1;
        repeat (SYNC_STAGES) @(negedge clk);
        xfer(24'h654321, got, lat);
        check("coin_data", 32'(got), 32'h654321);
        check("coin_lat", lat, 4);
        check("coin_fx_off", 32'(fx_active), 32'h0);
        check("coin_no_flush_yet", n_frst - snap_r, 0);
        @(negedge clk);
        check("coin_flush", 32'(flt_reset), 32'h1);
        @(negedge clk);
        check("coin_fx_on", 32'(fx_active), 32'h1);

        fx_req = 1'b0;
        repeat (6) @(negedge clk);
        mute = 1'b1;
        in_sample = 24'h0F0F0F;
        in_strobe = 1'b1;
        @(negedge clk);
        in_strobe = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("wrst_flt_data", 32'(flt_data), 32'h0);
        check("wrst_out_sample", 32'(out_sample), 32'h0);
        check("wrst_flags", 32'({flt_wren, flt_reset, out_strobe, fx_active,
                                 flt_on, busy, overrun, timeout_err}), 32'h0);
        snap_o = n_ostb;
        snap_w = n_wren;
        reset = 1'b0;
        mute = 1'b0;
        repeat (20) @(negedge clk);
        check("wrst_no_out", n_ostb - snap_o, 0);
        check("wrst_no_wren", n_wren - snap_w, 0);
        xfer(24'h0ABCDE, got, lat);
        check("resume_data", 32'(got), 32'h0ABCDE);
        check("resume_lat", lat, 4);
        repeat (3) @(negedge clk);

        check("no_double_pulse", n_dbl, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_avg_ctrl.md
MOVE_AVG_CTRL -- requirements
Module: move_avg_ctrl

Interface
REQ-001 Parameter WARMUP, default 8: number of filtered samples discarded after filter enable.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles in WAIT for flt_valid.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth for fx_req.
REQ-004 Reset is reset, synchronous, active-high; clock is clk.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 in_sample  in  24  signed PCM sample from codec.
REQ-008 in_strobe  in  1  one-cycle pulse, in_sample valid.
REQ-009 fx_req  in  1  asynchronous user filter-enable level.
REQ-010 clr_err  in  1  clears sticky error flags.
REQ-011 flt_data  out  24  sample driven to filter input.
REQ-012 flt_wren  out  1  one-cycle write strobe to filter.
REQ-013 flt_on  out  1  filter enable; equals fx_active.
REQ-014 flt_reset  out  1  one-cycle filter reset pulse.
REQ-015 flt_out  in  24  signed filter result.
REQ-016 flt_valid  in  1  filter result valid.
REQ-017 out_sample  out  24  signed processed sample.
REQ-018 out_strobe  out  1  one-cycle pulse, out_sample valid.
REQ-019 fx_active  out  1  filtered path selected.
REQ-020 busy  out  1  high when state is not IDLE.
REQ-021 overrun  out  1  sticky: in_strobe arrived while busy.
REQ-022 timeout_err  out  1  sticky: flt_valid missing within TIMEOUT.

Function
REQ-023 fx_req SHALL pass through a SYNC_STAGES flip-flop synchronizer before use (fx_sync).
REQ-024 FSM states SHALL be IDLE, ISSUE, WAIT, FLUSH.
REQ-025 IDLE + in_strobe: latch in_sample into flt_data and a bypass register; go to ISSUE.
REQ-026 ISSUE: flt_wren=1 for exactly one cycle; clear the timer; go to WAIT.
REQ-027 WAIT + flt_valid: out_sample = flt_out if fx_active and warm_cnt==WARMUP, else the bypass register; out_strobe=1 on the next cycle; warm_cnt increments, saturating at WARMUP; go to IDLE.
REQ-028 WAIT with timer==TIMEOUT and no flt_valid: set timeout_err; out_sample = bypass register; out_strobe pulses; warm_cnt unchanged; go to IDLE.
REQ-029 Latency: in_strobe to out_strobe SHALL be 3 + (cycles in WAIT up to and including flt_valid); with a 1-cycle filter this is 4 cycles.
REQ-030 IDLE, no in_strobe, fx_sync=1, fx_active=0: go to FLUSH.
REQ-031 FLUSH: flt_reset=1 for one cycle; warm_cnt=0; fx_active=1; return to IDLE.
REQ-032 IDLE, no in_strobe, fx_sync=0, fx_active=1: fx_active=0 at the next edge with no flush; warm_cnt=0.
REQ-033 in_strobe in IDLE SHALL take priority over a pending mode change; the change is applied at the next idle cycle without a strobe.
REQ-034 in_strobe in ISSUE, WAIT or FLUSH: sample dropped; overrun set; FSM unaffected.
REQ-035 flt_valid outside WAIT SHALL be ignored.
REQ-036 clr_err clears overrun and timeout_err; a set event in the same cycle wins.
REQ-037 out_strobe, flt_wren and flt_reset SHALL never be high for two consecutive cycles.
REQ-038 All data paths are 24-bit signed pass-through; no arithmetic on samples.

Reset
REQ-039 During reset: state=IDLE; flt_data, out_sample=0; flt_wren, flt_reset, out_strobe, fx_active, flt_on, busy, overrun, timeout_err=0; warm_cnt=0; synchronizer cleared.
REQ-040 Reset mid-transaction SHALL abort it with no out_strobe, no flt_wren and no flt_reset in or after the reset cycle.

Verification
REQ-041 fx_req=0, in_strobe with in_sample=0x000100, 1-cycle filter model -> out_sample=0x000100, out_strobe exactly 4 cycles later, fx_active=0.
REQ-042 fx_req 0->1, then 10 strobes of 0x7FFFFF -> one flt_reset pulse; first 8 outputs are bypass, outputs 9 and 10 equal flt_out.
REQ-043 fx_active=1 with filter model never asserting flt_valid -> out_strobe after TIMEOUT cycles in WAIT, out_sample=bypass, timeout_err=1 until clr_err.
REQ-044 Second in_strobe 2 cycles after the first -> overrun=1, only one out_strobe, and the second sample never appears on flt_data.
REQ-045 in_strobe coincident with synchronized fx_req rise in IDLE -> sample processed first, FLUSH follows on the next idle cycle.
REQ-046 reset asserted during WAIT -> all outputs 0 next cycle, no out_strobe, and normal operation resumes afterwards.
